// File: rtl/stream_mux_nto1_pkg.sv
// ============================================================================
//  Module   : stream_mux_nto1_pkg
//  Brief    : Shared constants and width helper for the N-to-1 stream mux.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package stream_mux_nto1_pkg;

    localparam int c_mode_sel = 0;
    localparam int c_mode_rr  = 1;

    // Index width for n channels; never below one bit so a 1-bit select exists.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_mux_nto1_rr_arbiter.sv
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin pick, searching upward from ptr+1.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int SELW     = 2
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [SELW-1:0]     ptr_i,
    output logic [CHANNELS-1:0] grant_o,
    output logic [SELW-1:0]     idx_o,
    output logic                any_o
);

    logic            w_found;
    logic [SELW-1:0] w_k;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            w_k = SELW'((int'(ptr_i) + i) % CHANNELS);
            if (!w_found && req_i[w_k]) begin
                w_found        = 1'b1;
                idx_o          = w_k;
                grant_o[w_k]   = 1'b1;
            end
        end
    end

    assign any_o = w_found;

endmodule

`default_nettype wire

// File: rtl/stream_mux_nto1.sv
// ============================================================================
//  Module   : stream_mux_nto1
//  Brief    : N-to-1 valid/ready selector with one registered output stage.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stream_mux_nto1
    import stream_mux_nto1_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    parameter  int MODE     = c_mode_sel,
    localparam int SELW     = clog2_min1(CHANNELS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [CHANNELS-1:0]       valid_i,
    input  logic [CHANNELS*WIDTH-1:0] data_i,
    output logic [CHANNELS-1:0]       ready_o,
    input  logic [SELW-1:0]           sel_i,
    output logic                      valid_o,
    output logic [WIDTH-1:0]          data_o,
    output logic [SELW-1:0]           grant_o,
    input  logic                      ready_i
);

    localparam int c_padn = 1 << SELW;

    logic                r_valid;
    logic [WIDTH-1:0]    r_data;
    logic [SELW-1:0]     r_grant;

    logic                w_can_load;
    logic                w_load;
    logic                w_chosen_any;
    logic [SELW-1:0]     w_chosen_idx;
    logic [CHANNELS-1:0] w_chosen_1h;
    logic [WIDTH-1:0]    w_chosen_data;

    assign w_can_load = !r_valid || ready_i;
    assign w_load     = w_can_load && w_chosen_any;

    generate
        if (MODE == c_mode_rr) begin : g_rr
            logic [SELW-1:0] r_ptr;
            logic            w_sel_unused;

            assign w_sel_unused = ^sel_i;

            rr_arbiter #(
                .CHANNELS (CHANNELS),
                .SELW     (SELW)
            ) u_arb (
                .req_i    (valid_i),
                .ptr_i    (r_ptr),
                .grant_o  (w_chosen_1h),
                .idx_o    (w_chosen_idx),
                .any_o    (w_chosen_any)
            );

            // Pointer only advances on an accepted word, so stalls keep fairness.
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_ptr <= SELW'(CHANNELS - 1);
                end else if (w_load) begin
                    r_ptr <= w_chosen_idx;
                end
            end
        end else begin : g_sel
            // Zero-padded so out-of-range selects read as "not valid".
            logic [c_padn-1:0] w_valid_pad;

            always_comb begin
                w_valid_pad                 = '0;
                w_valid_pad[CHANNELS-1:0]   = valid_i;
            end

            assign w_chosen_idx = sel_i;
            assign w_chosen_any = w_valid_pad[sel_i];

            always_comb begin
                w_chosen_1h = '0;
                for (int k = 0; k < CHANNELS; k++) begin
                    w_chosen_1h[k] = w_chosen_any && (sel_i == SELW'(k));
                end
            end
        end
    endgenerate

    always_comb begin
        w_chosen_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_chosen_1h[k]) begin
                w_chosen_data = w_chosen_data | data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign ready_o = w_chosen_1h & valid_i & {CHANNELS{w_can_load && rst_i}};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_grant <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= w_chosen_data;
            r_grant <= w_chosen_idx;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign grant_o = r_grant;

endmodule

`default_nettype wire
